matmul_uart_sequencer: RTL
==========================

# matmul_uart_sequencer

Controls the 4x4 systolic matrix multiplier. It collects 32 operand bytes from the UART receiver: 16 bytes for A, then 16 bytes for B, both row-major. It then pulses the multiplier start, waits the multiplier's fixed latency and captures the 16 32-bit results. Finally it streams the results out as 64 bytes over a valid/ready byte interface that feeds the UART transmitter. It sits between `uart_rx`, `systolic_matrix_mul_4x4` and the TX path, and replaces ad-hoc buffer/trigger logic in the top level.

## Interface
- `N_DATA_BITS`, default 8: UART byte width. Only 8 is supported.
- `RESULT_WIDTH`, default 32: width of each result element.
- `MUL_LATENCY`, default 12: cycles from `o_mul_start` to valid `i_result`. Must be ≥ 1.
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte load timeout. Used only with `MATMUL_SEQ_TIMEOUT_EN`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`, in, 1: system clock (uart_clk domain).
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_rx_data`, in, 8: received byte.
- `i_rx_valid`, in, 1: one-cycle strobe qualifying `i_rx_data`.
- `o_mat_a`, out, 128: A; `[127:120]` = A[0][0], `[7:0]` = A[3][3].
- `o_mat_b`, out, 128: B; same packing as `o_mat_a`.
- `o_mul_start`, out, 1: one-cycle multiply start pulse.
- `i_result`, in, 16×`RESULT_WIDTH`: C packed with C[0][0] in the top word and C[3][3] in the bottom word.
- `o_tx_data`, out, 8: byte to transmit.
- `o_tx_valid`, out, 1: `o_tx_data` is valid.
- `i_tx_ready`, in, 1: transmitter accepts the byte this cycle.
- `o_busy`, out, 1: high in every state except LOAD_A with byte count 0.
- `o_overrun`, out, 1: one-cycle pulse when a byte is dropped.
- `o_error`, out, 1: one-cycle pulse on load timeout. Tied to 0 without the macro.

## Operation
- States: LOAD_A, LOAD_B, START, WAIT, CAPTURE, SEND. Reset state is LOAD_A.
- Byte counter `cnt` is 5 bits and counts 0..31.
- In LOAD_A and LOAD_B, each `i_rx_valid` writes the byte to matrix slot `cnt[3:0]` (slot 0 is the MSB byte) and increments `cnt`.
  - Accepting byte 15 moves to LOAD_B.
  - Accepting byte 31 moves to START and wraps `cnt` to 0.
- Matrix slots are overwritten in place; there is no clear between jobs. `o_mat_a`/`o_mat_b` stay stable from START until the first byte of the next job.
- START: `o_mul_start`=1 for exactly one cycle, then WAIT.
- WAIT: a latency counter runs `MUL_LATENCY` cycles, then the block moves to CAPTURE.
- CAPTURE: the full `i_result` is latched into a 512-bit shift register in one cycle, then SEND.
- SEND: 64 bytes in order C[0][0]..C[3][3], each element MSB byte first.
  - `o_tx_data` is the top byte of the shift register.
  - On `o_tx_valid && i_tx_ready` the register shifts by 8 and a 6-bit send counter increments.
  - After the 64th accepted byte the block goes to LOAD_A. `o_tx_valid` is 0 the next cycle.
- `i_rx_valid` in START, WAIT, CAPTURE or SEND: the byte is dropped, `o_overrun` pulses, and no counters change.
- Reset, at any time including mid-load or mid-send, returns outputs and counters to their reset values and the state to LOAD_A.

## Timing
- Reset values: `o_mat_a`=0, `o_mat_b`=0, `o_mul_start`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_overrun`=0, `o_error`=0.
- All outputs are registered.
- The matrix slot is visible on `o_mat_*` the cycle after `i_rx_valid`.
- `o_mul_start` is high on the cycle after the 32nd byte strobe.
- CAPTURE occurs `MUL_LATENCY`+1 cycles after `o_mul_start`.
- `o_tx_valid` rises 1 cycle after CAPTURE.
- TX handshake:
  - `o_tx_valid` never drops and `o_tx_data` never changes while `i_tx_ready`=0.
  - With ready held high, one byte transfers per cycle, so 64 cycles in total.
- `o_overrun` is 1 cycle after the dropped strobe.

## Configuration
- `MATMUL_SEQ_TIMEOUT_EN` defined:
  - In LOAD_A/LOAD_B with `cnt`≠0, an idle counter resets on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, `cnt` is cleared, the state returns to LOAD_A and `o_error` pulses once.
  - Matrix contents are kept; the next job overwrites them.
- Not defined: no idle counter, `o_error` is constant 0, and a partial load waits indefinitely.

## Test plan
- A = identity (bytes 01 00 00 00 00 01 …), B = 1..16 → one `o_mul_start` pulse exactly 1 cycle after byte 32. The 64 TX bytes are 00 00 00 01, 00 00 00 02, …, 00 00 00 10, i.e. C = B.
- Same job with `i_tx_ready` low for 10 cycles during byte 5 → `o_tx_valid` stays high and `o_tx_data`=00 is stable. Exactly 64 bytes are delivered with none duplicated.
- Byte 0xAA sent during WAIT → `o_overrun` pulses once. Results are unchanged and the next job loads from slot A[0][0].
- Reset after 20 bytes, then 32 new bytes → the result matches the new matrices only. All outputs were 0 on the cycle after reset.
- With the macro and `TIMEOUT_CYCLES`=100: 5 bytes then 100 idle cycles → `o_error` pulses, `o_busy`=0, and the next 32 bytes form a fresh job. Without the macro: no `o_error`, and the block stays in LOAD_A with `cnt`=5.
- A second back-to-back job immediately after SEND → correct results, proving the return to LOAD_A and operand overwrite.

Source files
------------

// File: rtl/matmul_uart_sequencer.sv
// Sequencer for the 4x4 systolic multiplier: loads A/B operand bytes from UART RX, starts the
// multiply, captures C and streams it out byte-wise. Optional load timeout: MATMUL_SEQ_TIMEOUT_EN.
module matmul_uart_sequencer #(
  parameter int unsigned N_DATA_BITS    = 8,
  parameter int unsigned RESULT_WIDTH   = 32,
  parameter int unsigned MUL_LATENCY    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_DATA_BITS-1:0]       i_rx_data,
  input  logic                         i_rx_valid,
  output logic [16*N_DATA_BITS-1:0]    o_mat_a,
  output logic [16*N_DATA_BITS-1:0]    o_mat_b,
  output logic                         o_mul_start,
  input  logic [16*RESULT_WIDTH-1:0]   i_result,
  output logic [N_DATA_BITS-1:0]       o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic                         o_error
);

  localparam int unsigned MAT_W      = 16 * N_DATA_BITS;
  localparam int unsigned RES_W      = 16 * RESULT_WIDTH;
  localparam int unsigned SEND_BYTES = RES_W / N_DATA_BITS;
  localparam int unsigned SEND_W     = $clog2(SEND_BYTES);
  localparam int unsigned LAT_W      = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [LAT_W-1:0]     lat_q, lat_nxt;
  logic [SEND_W-1:0]    send_q, send_nxt;
  logic [RES_W-1:0]     shreg_q, shreg_nxt;
  logic [N_DATA_BITS-1:0] mat_a_q [16];
  logic [N_DATA_BITS-1:0] mat_b_q [16];
  logic                 mul_start_q, tx_valid_q, busy_q, overrun_q;
  logic                 we_a_c, we_b_c, overrun_c, load_c, timeout_c;

  assign load_c = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);

  // Next-state, counters and write enables
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    lat_nxt   = lat_q;
    send_nxt  = send_q;
    shreg_nxt = shreg_q;
    we_a_c    = 1'b0;
    we_b_c    = 1'b0;
    overrun_c = 1'b0;
    unique case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (i_rx_valid) begin
          we_a_c  = (state_q == S_LOAD_A);
          we_b_c  = (state_q == S_LOAD_B);
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(15)) begin
            state_nxt = S_LOAD_B;
          end
          if (cnt_q == CNT_W'(31)) begin
            state_nxt = S_START;
            cnt_nxt   = '0;
          end
        end else if (timeout_c) begin
          state_nxt = S_LOAD_A;
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
        lat_nxt   = '0;
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(MUL_LATENCY - 1)) begin
          state_nxt = S_CAPTURE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        shreg_nxt = i_result;
        send_nxt  = '0;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && i_tx_ready) begin
          shreg_nxt = {shreg_q[RES_W-N_DATA_BITS-1:0], N_DATA_BITS'(0)};
          send_nxt  = send_q + 1'b1;
          if (send_q == SEND_W'(SEND_BYTES - 1)) begin
            state_nxt = S_LOAD_A;
          end
        end
      end
      default: begin
        state_nxt = S_LOAD_A;
        cnt_nxt   = '0;
      end
    endcase
    if (!load_c && i_rx_valid) begin
      overrun_c = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      lat_q       <= '0;
      send_q      <= '0;
      shreg_q     <= '0;
      mul_start_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mat_a_q[i] <= '0;
        mat_b_q[i] <= '0;
      end
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      lat_q       <= lat_nxt;
      send_q      <= send_nxt;
      shreg_q     <= shreg_nxt;
      mul_start_q <= (state_nxt == S_START);
      tx_valid_q  <= (state_nxt == S_SEND);
      busy_q      <= !((state_nxt == S_LOAD_A) && (cnt_nxt == '0));
      overrun_q   <= overrun_c;
      if (we_a_c) begin
        mat_a_q[cnt_q[3:0]] <= i_rx_data;
      end
      if (we_b_c) begin
        mat_b_q[cnt_q[3:0]] <= i_rx_data;
      end
    end
  end

  // Slot 0 occupies the most significant byte of each matrix bus
  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign o_mat_a[MAT_W-1-g*N_DATA_BITS -: N_DATA_BITS] = mat_a_q[g];
    assign o_mat_b[MAT_W-1-g*N_DATA_BITS -: N_DATA_BITS] = mat_b_q[g];
  end

  assign o_mul_start = mul_start_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = shreg_q[RES_W-1 -: N_DATA_BITS];
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_q;
  logic              error_q;

  // Abandon a partial load after TIMEOUT_CYCLES cycles without a byte
  assign timeout_c = load_c && (cnt_q != '0) && !i_rx_valid &&
                     (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_q  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= timeout_c;
      if (!load_c || (cnt_q == '0) || i_rx_valid || timeout_c) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign o_error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
  assign o_error        = 1'b0;
`endif

endmodule
